// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin owner of the single-port memory bus.
// One transaction at a time; each bus cycle is bounded by a timeout so a
// memory that never answers cannot hang the requesters.
module mem_bus_arbiter #(
  parameter int NREQ    = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [NREQ-1:0]   err,
  output logic [DW-1:0]     rdata,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic              mem_ready,
  input  logic [DW-1:0]     mem_rdata
);

  localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [SW-1:0] LAST_RST = SW'(NREQ - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t            state, state_n;
  logic [SW-1:0]     last, last_n;
  logic [SW-1:0]     sel, sel_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [NREQ-1:0]   gnt_n, done_n, err_n;
  logic [DW-1:0]     rdata_n;
  logic              mem_valid_n, mem_we_n;
  logic [AW-1:0]     mem_addr_n;
  logic [DW-1:0]     mem_wdata_n;

  logic [AW-1:0]     addr_a  [NREQ];
  logic [DW-1:0]     wdata_a [NREQ];
  logic [SW-1:0]     cand;
  logic [SW-1:0]     win_idx;
  logic              win_vld;
  logic [NREQ-1:0]   win_oh;

  // Flat per-requester buses split into indexable lanes.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
    assign addr_a[gi]  = addr[gi*AW +: AW];
    assign wdata_a[gi] = wdata[gi*DW +: DW];
  end

  // Round-robin pick: first requester at or after last+1, wrapping.
  always_comb begin
    cand    = '0;
    win_idx = '0;
    win_vld = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = SW'((int'(last) + k) % NREQ);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
    win_oh          = '0;
    win_oh[win_idx] = 1'b1;
  end

  // State register; reset aborts any bus cycle in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state and next-output decode. Completion clears gnt/mem_valid and
  // moves the round-robin pointer to the owner that just finished.
  always_comb begin
    state_n     = state;
    last_n      = last;
    sel_n       = sel;
    cnt_n       = cnt;
    gnt_n       = gnt;
    done_n      = '0;
    err_n       = '0;
    rdata_n     = rdata;
    mem_valid_n = mem_valid;
    mem_we_n    = mem_we;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_n     = BUSY;
          sel_n       = win_idx;
          gnt_n       = win_oh;
          mem_valid_n = 1'b1;
          mem_we_n    = we[win_idx];
          mem_addr_n  = addr_a[win_idx];
          mem_wdata_n = wdata_a[win_idx];
          cnt_n       = '0;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          // ready on the timeout cycle still counts as a normal completion
          if (!mem_we) rdata_n = mem_rdata;
          done_n      = gnt;
          last_n      = sel;
          gnt_n       = '0;
          mem_valid_n = 1'b0;
          state_n     = IDLE;
        end else if (cnt == CNT_LAST) begin
          done_n      = gnt;
          err_n       = gnt;
          last_n      = sel;
          gnt_n       = '0;
          mem_valid_n = 1'b0;
          state_n     = IDLE;
        end else if (cnt != CNT_MAX) begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Registered datapath and handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last      <= LAST_RST;
      sel       <= '0;
      cnt       <= '0;
      gnt       <= '0;
      done      <= '0;
      err       <= '0;
      rdata     <= '0;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      last      <= last_n;
      sel       <= sel_n;
      cnt       <= cnt_n;
      gnt       <= gnt_n;
      done      <= done_n;
      err       <= err_n;
      rdata     <= rdata_n;
      mem_valid <= mem_valid_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: random requesters and a random-latency memory; a
// transaction-level model predicts each grant and completion into queues
// that a negedge monitor drains against the DUT.
module tb_mem_bus_arbiter;
  localparam int NREQ = 2, AW = 32, DW = 32, TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst;
  logic [NREQ-1:0] req, we, gnt, done, err;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic mem_valid, mem_we, mem_ready;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata));

  typedef struct { int cyc; logic [NREQ-1:0] oh; logic [AW-1:0] a; logic w; logic [DW-1:0] wd; } gexp_t;
  typedef struct { int cyc; logic [NREQ-1:0] oh; logic e; logic [DW-1:0] rd; } cexp_t;
  typedef struct { int d; logic [DW-1:0] v; } rsp_t;

  gexp_t gq[$];
  cexp_t cq[$];
  rsp_t  dq[$];

  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic bit_of(input logic [NREQ-1:0] v, input int j);
    return |(v & (NREQ'(1) << j));
  endfunction

  // stimulus sources: random lanes or directed vectors
  logic dmode = 1'b0, en = 1'b0;
  logic s_req [NREQ], s_we [NREQ];
  logic [AW-1:0] s_addr [NREQ];
  logic [DW-1:0] s_wdata [NREQ];
  logic [NREQ-1:0] d_req = '0, d_we = '0;
  logic [AW-1:0] d_addr [NREQ];
  logic [DW-1:0] d_wdata [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_mux
    assign req[gi]              = dmode ? d_req[gi]   : s_req[gi];
    assign we[gi]               = dmode ? d_we[gi]    : s_we[gi];
    assign addr[gi*AW +: AW]    = dmode ? d_addr[gi]  : s_addr[gi];
    assign wdata[gi*DW +: DW]   = dmode ? d_wdata[gi] : s_wdata[gi];
  end

  // ---------------- reference model (transaction level) ----------------
  int cyc = 0;
  bit m_busy = 1'b0;
  int m_last = NREQ - 1;
  int m_own, m_end, m_w, m_dur, force_d = -1;
  logic [DW-1:0] m_rdata = '0;
  int dtab [8] = '{0, 1, 2, 3, TIMEOUT-2, TIMEOUT-1, TIMEOUT, 3*TIMEOUT};
  rsp_t  m_rs;
  gexp_t m_g;
  cexp_t m_c;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      if (m_busy) void'(cq.pop_back());
      m_busy = 1'b0; m_last = NREQ - 1; m_rdata = '0;
    end else if (m_busy) begin
      if (cyc == m_end) begin m_busy = 1'b0; m_last = m_own; end
    end else if (|req) begin
      m_w = -1;
      for (int k = 1; k <= NREQ; k++)
        if (m_w < 0 && bit_of(req, (m_last + k) % NREQ)) m_w = (m_last + k) % NREQ;
      m_rs.d = (force_d >= 0) ? force_d : dtab[$urandom_range(0, 7)];
      m_rs.v = $urandom;
      // ready after d wait cycles; no ready within TIMEOUT cycles -> abort
      m_dur = (m_rs.d < TIMEOUT) ? m_rs.d + 1 : TIMEOUT;
      m_g.cyc = cyc; m_g.oh = NREQ'(1) << m_w; m_g.a = addr[m_w*AW +: AW];
      m_g.w = bit_of(we, m_w); m_g.wd = wdata[m_w*DW +: DW];
      m_c.cyc = cyc + m_dur; m_c.oh = m_g.oh; m_c.e = (m_rs.d >= TIMEOUT);
      if (!m_g.w && !m_c.e) m_rdata = m_rs.v;
      m_c.rd = m_rdata;
      gq.push_back(m_g); cq.push_back(m_c); dq.push_back(m_rs);
      m_busy = 1'b1; m_own = m_w; m_end = cyc + m_dur;
    end
  end

  // ---------------- memory responder ----------------
  bit r_act = 1'b0;
  int r_cnt;
  rsp_t r_rs;
  initial begin mem_ready = 1'b0; mem_rdata = '0; end
  always @(negedge clk) begin
    if (mem_valid && !r_act) begin
      r_rs.d = 1000; r_rs.v = '0;
      if (dq.size() > 0) r_rs = dq.pop_front();
      r_cnt = 0; r_act = 1'b1;
    end else if (!mem_valid) r_act = 1'b0;
    if (r_act) begin
      mem_ready = (r_cnt == r_rs.d);
      mem_rdata = (r_cnt == r_rs.d) ? r_rs.v : $urandom;
      r_cnt++;
    end else begin
      mem_ready = 1'b0;
      mem_rdata = $urandom;
    end
  end

  // ---------------- monitor ----------------
  logic pv = 1'b0;
  gexp_t mg;
  cexp_t mc;
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_valid && !pv) begin
        if (gq.size() == 0) chk("grant_unexpected", {32'd0, cyc}, 64'd0);
        else begin
          mg = gq.pop_front();
          chk("grant_cycle", 64'(cyc), 64'(mg.cyc));
          chk("gnt", 64'(gnt), 64'(mg.oh));
          chk("mem_addr", 64'(mem_addr), 64'(mg.a));
          chk("mem_we", 64'(mem_we), 64'(mg.w));
          chk("mem_wdata", 64'(mem_wdata), 64'(mg.wd));
        end
      end
      if (|done || |err) begin
        if (cq.size() == 0) chk("done_unexpected", 64'({done, err}), 64'd0);
        else begin
          mc = cq.pop_front();
          chk("done_cycle", 64'(cyc), 64'(mc.cyc));
          chk("done", 64'(done), 64'(mc.oh));
          chk("err", 64'(err), mc.e ? 64'(mc.oh) : 64'd0);
          chk("rdata", 64'(rdata), 64'(mc.rd));
          chk("bus_released", 64'({gnt, mem_valid}), 64'd0);
        end
      end
      while (gq.size() > 0 && gq[0].cyc < cyc) begin
        chk("grant_missing", 64'(mem_valid), 64'(~pv));
        void'(gq.pop_front());
      end
      while (cq.size() > 0 && cq[0].cyc < cyc) begin
        chk("done_missing", 64'(done), 64'(cq[0].oh));
        void'(cq.pop_front());
      end
    end
    pv = mem_valid;
  end

  // ---------------- random requesters ----------------
  int st [NREQ], gap [NREQ], wt [NREQ];
  initial begin
    for (int i = 0; i < NREQ; i++) begin
      s_req[i] = 1'b0; s_we[i] = 1'b0; s_addr[i] = '0; s_wdata[i] = '0;
      st[i] = 0; gap[i] = i; wt[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (st[i] == 0) begin
          if (gap[i] > 0) gap[i]--;
          else if (en) begin
            s_req[i] = 1'b1; s_addr[i] = $urandom; s_we[i] = 1'($urandom_range(0, 1));
            s_wdata[i] = $urandom; st[i] = 1; wt[i] = 0;
          end
        end else begin
          wt[i]++;
          if (bit_of(done, i)) begin
            if (en && $urandom_range(0, 1) == 1) begin
              s_addr[i] = $urandom; s_we[i] = 1'($urandom_range(0, 1));
              s_wdata[i] = $urandom; s_req[i] = 1'b1; wt[i] = 0;
            end else begin
              s_req[i] = 1'b0; gap[i] = $urandom_range(0, 4); st[i] = 0;
            end
          end else if (bit_of(gnt, i) && s_req[i] && $urandom_range(0, 15) == 0) begin
            s_req[i] = 1'b0;  // withdrawn mid-transaction; done must still arrive
          end else if (wt[i] > 400) begin
            s_req[i] = 1'b0; st[i] = 0;  // model's missing-event checks report this
          end
        end
      end
    end
  end

  task automatic drain();
    int k;
    k = 0;
    while (k < 1000 && (m_busy || gq.size() != 0 || cq.size() != 0 || req != '0)) begin
      @(negedge clk); k++;
    end
    chk("drain_idle", 64'(k < 1000), 64'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) begin d_addr[i] = '0; d_wdata[i] = '0; end
    repeat (2) @(negedge clk);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_done_err", 64'({done, err}), 64'd0);
    chk("rst_mem_valid_we", 64'({mem_valid, mem_we}), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    rst = 1'b0;
    en = 1'b1;
    repeat (3000) @(negedge clk);
    en = 1'b0;
    drain();

    // abort in second BUSY cycle, then both pending: requester 0 first
    dmode = 1'b1;
    d_addr[0] = 32'h0000_0100; d_we[0] = 1'b0;
    d_addr[1] = 32'h0000_0200; d_we[1] = 1'b1; d_wdata[1] = 32'hCAFE_F00D;
    force_d = 100;
    d_req = 2'b01;
    for (int k = 0; k < 10 && !gnt[0]; k++) @(negedge clk);
    chk("dir_grant0", 64'(gnt), 64'd1);
    @(posedge clk); #2;
    rst = 1'b1; d_req = 2'b11;
    #1;
    chk("abort_mem_valid", 64'(mem_valid), 64'd0);
    chk("abort_gnt", 64'(gnt), 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", 64'({done, err}), 64'd0);
    end
    force_d = 0;
    rst = 1'b0;
    repeat (12) @(negedge clk);
    d_req = '0;
    drain();
    force_d = -1;
    dmode = 1'b0;

    chk("grant_queue_empty", 64'(gq.size()), 64'd0);
    chk("done_queue_empty", 64'(cq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
